// File: rtl/vga_pkg.sv
// Shared VGA definitions: screen bounds, colour constants and the row-sequencer state type.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] CYAN  = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_DRAW,
    ST_GAP,
    ST_FIN
  } row_state_e;

endpackage

// File: rtl/box_scan.sv
// Enable-driven 2-D counter walking a BOX x BOX square row-major (ex fastest).
// It wraps back to (0,0) after the last pixel, so it is ready for the next slot.
module box_scan #(
  parameter  int BOX = 16,
  localparam int CW  = (BOX > 1) ? $clog2(BOX) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  output logic [CW-1:0] ex,
  output logic [CW-1:0] ey,
  output logic          last
);

  localparam logic [CW-1:0] MAX = CW'(BOX - 1);

  logic [CW-1:0] ex_reg;
  logic [CW-1:0] ey_reg;

  // Advance one pixel per enabled cycle; ey steps when ex wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_reg <= '0;
      ey_reg <= '0;
    end else if (en) begin
      if (ex_reg == MAX) begin
        ex_reg <= '0;
        ey_reg <= (ey_reg == MAX) ? '0 : ey_reg + CW'(1);
      end else begin
        ex_reg <= ex_reg + CW'(1);
      end
    end
  end

  assign ex   = ex_reg;
  assign ey   = ey_reg;
  assign last = (ex_reg == MAX) && (ey_reg == MAX);

endmodule

// File: rtl/symbol_row_ctrl.sv
// Row sequencer: walks NUM_SLOTS symbol slots left to right, optionally erasing each
// slot box to black, then enabling the symbol renderer at the slot base until it
// reports completion. Muxes erase pixels or renderer pixels onto the VGA plot port.
module symbol_row_ctrl
  import vga_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int X0        = 8,
  parameter int Y0        = 40,
  parameter int PITCH     = 20,
  parameter int BOX       = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       erase,
  output logic       busy,
  output logic       done,
  output logic       draw_en,
  output logic [7:0] sym_x,
  output logic [6:0] sym_y,
  input  logic       sym_done,
  input  logic [7:0] rend_x,
  input  logic [6:0] rend_y,
  input  logic [2:0] rend_colour,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic [2:0] pix_colour,
  output logic       plot
);

  localparam int SW   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int EW   = (BOX > 1) ? $clog2(BOX) : 1;
  localparam int NTAB = 1 << SW;

  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SLOTS - 1);
  localparam logic [6:0]    BASE_Y    = 7'(Y0);

  row_state_e    state_reg;
  logic [SW-1:0] slot_reg;
  logic          erase_q_reg;
  logic          first_draw_reg;

  logic [EW-1:0] ex;
  logic [EW-1:0] ey;
  logic          scan_last;
  logic          scan_en;

  logic [7:0]    base_tbl [NTAB];
  logic [7:0]    base_x;

  // Slot base x positions as a constant table; unreachable entries read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < NTAB; gi++) begin : g_base
      if (gi < NUM_SLOTS) begin : g_used
        assign base_tbl[gi] = 8'(X0 + gi * PITCH);
      end else begin : g_unused
        assign base_tbl[gi] = 8'd0;
      end
    end
  endgenerate

  assign base_x  = base_tbl[slot_reg];
  assign scan_en = (state_reg == ST_ERASE);

  box_scan #(
    .BOX (BOX)
  ) u_scan (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (scan_en),
    .ex      (ex),
    .ey      (ey),
    .last    (scan_last)
  );

  // Row sequencing FSM with slot counter, latched erase mode and first-draw marker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      slot_reg       <= '0;
      erase_q_reg    <= 1'b0;
      first_draw_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            erase_q_reg    <= erase;
            slot_reg       <= '0;
            first_draw_reg <= 1'b1;
            state_reg      <= erase ? ST_ERASE : ST_DRAW;
          end
        end
        ST_ERASE: begin
          if (scan_last) begin
            first_draw_reg <= 1'b1;
            state_reg      <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          // Renderer output lags by a cycle, so only the first DRAW cycle is unplotted.
          first_draw_reg <= 1'b0;
          if (sym_done) begin
            state_reg <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (slot_reg == LAST_SLOT) begin
            state_reg <= ST_FIN;
          end else begin
            slot_reg       <= slot_reg + SW'(1);
            first_draw_reg <= 1'b1;
            state_reg      <= erase_q_reg ? ST_ERASE : ST_DRAW;
          end
        end
        ST_FIN: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_reg != ST_IDLE);
  assign done    = (state_reg == ST_FIN);
  assign draw_en = (state_reg == ST_DRAW);
  assign sym_x   = draw_en ? base_x : 8'd0;
  assign sym_y   = draw_en ? BASE_Y : 7'd0;

  // Plot-port mux: erase pixels in ERASE, renderer pixels in DRAW, idle zeros otherwise.
  always_comb begin
    pix_x      = 8'd0;
    pix_y      = 7'd0;
    pix_colour = 3'b000;
    plot       = 1'b0;
    case (state_reg)
      ST_ERASE: begin
        pix_x      = base_x + 8'(ex);
        pix_y      = BASE_Y + 7'(ey);
        pix_colour = BLACK;
        plot       = 1'b1;
      end
      ST_DRAW: begin
        pix_x      = rend_x;
        pix_y      = rend_y;
        pix_colour = rend_colour;
        plot       = !first_draw_reg;
      end
      default: begin
        plot = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_symbol_row_ctrl.sv
// Directed bench for symbol_row_ctrl: a 4-slot row (with stubbed renderer) and a
// single-slot instance, covering plain rows, erase rows, start spam, spurious
// sym_done, and an asynchronous reset in the middle of a row.
module tb_symbol_row_ctrl;
  import vga_pkg::*;

  localparam int TDRAW = 52;   // DRAW cycles per slot produced by the renderer stub

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, erase, spur;
  logic       busy, done, draw_en, plot, sym_done;
  logic [7:0] sym_x, rend_x, pix_x;
  logic [6:0] sym_y, rend_y, pix_y;
  logic [2:0] rend_colour, pix_colour;

  logic       start1, erase1;
  logic       busy1, done1, draw_en1, plot1, sym_done1;
  logic [7:0] sym_x1, pix_x1;
  logic [6:0] sym_y1, pix_y1;
  logic [2:0] pix_colour1;

  logic [7:0] stub_cnt  = '0;
  logic [7:0] stub_cnt1 = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Renderer stubs: count enabled cycles, pulse completion in the TDRAW-th one.
  always @(posedge clk) stub_cnt  <= draw_en  ? stub_cnt  + 8'd1 : 8'd0;
  always @(posedge clk) stub_cnt1 <= draw_en1 ? stub_cnt1 + 8'd1 : 8'd0;

  assign sym_done    = (draw_en && stub_cnt == 8'(TDRAW - 1)) || spur;
  assign rend_x      = sym_x + {4'b0000, stub_cnt[3:0]};
  assign rend_y      = sym_y + {3'b000, stub_cnt[7:4]};
  assign rend_colour = CYAN;
  assign sym_done1   = draw_en1 && stub_cnt1 == 8'(TDRAW - 1);

  symbol_row_ctrl u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .erase(erase),
    .busy(busy), .done(done), .draw_en(draw_en), .sym_x(sym_x), .sym_y(sym_y),
    .sym_done(sym_done), .rend_x(rend_x), .rend_y(rend_y), .rend_colour(rend_colour),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .plot(plot)
  );

  symbol_row_ctrl #(.NUM_SLOTS(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .erase(erase1),
    .busy(busy1), .done(done1), .draw_en(draw_en1), .sym_x(sym_x1), .sym_y(sym_y1),
    .sym_done(sym_done1), .rend_x(sym_x1), .rend_y(sym_y1), .rend_colour(CYAN),
    .pix_x(pix_x1), .pix_y(pix_y1), .pix_colour(pix_colour1), .plot(plot1)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one start, follow the whole row cycle by cycle and check it.
  task automatic run_row(input int id, input bit with_erase, input bit spam, input bit spur_en);
    int  busy_cyc = 0, done_cnt = 0, n_draw = 0, gaps = 0;
    int  eidx = 0, bad_e = 0, bad_d = 0, bad_o = 0, extra = 0;
    int  exp_busy;
    bit  prev_de = 1'b0, finished = 1'b0;
    exp_busy = 4 * ((with_erase ? 256 : 0) + TDRAW + 1) + 1;
    @(negedge clk);
    start = 1'b1;
    erase = with_erase;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      spur  = 1'b0;
      if (cyc == 0) begin
        check_val("first_busy", busy, 1);
        check_val("first_draw_en", draw_en, with_erase ? 0 : 1);
        check_val("first_plot", plot, with_erase ? 1 : 0);
      end
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (draw_en && !prev_de) begin
        check_val($sformatf("sym_x_slot%0d", n_draw), sym_x, 8 + 20 * n_draw);
        check_val($sformatf("sym_y_slot%0d", n_draw), sym_y, 40);
        check_val($sformatf("plot_first_draw%0d", n_draw), plot, 0);
        check_val($sformatf("erase_pixels_slot%0d", n_draw), eidx, with_erase ? 256 : 0);
        n_draw++;
        eidx = 0;
      end
      if (plot && !draw_en) begin
        if (pix_x !== 8'(8 + 20 * n_draw + eidx % 16) || pix_y !== 7'(40 + eidx / 16) ||
            pix_colour !== BLACK)
          bad_e++;
        if (spur_en && eidx == 100) spur = 1'b1;
        eidx++;
      end
      if (draw_en && plot) begin
        if (pix_x !== rend_x || pix_y !== rend_y || pix_colour !== rend_colour) bad_d++;
      end
      if (!draw_en && !plot) begin
        if (pix_x !== 8'd0 || pix_y !== 7'd0 || pix_colour !== 3'b000) bad_o++;
        if (prev_de && busy) gaps++;
      end
      if (spam && busy && !done && (cyc % 37) == 5) start = 1'b1;
      prev_de = draw_en;
      if (done_cnt > 0 && !busy) begin
        finished = 1'b1;
        break;
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    check_val("row_finished", finished, 1);
    check_val("busy_cycles", busy_cyc, exp_busy);
    check_val("done_pulses", done_cnt, 1);
    check_val("slots_drawn", n_draw, 4);
    check_val("gap_cycles", gaps, 4);
    check_val("erase_pix_errors", bad_e, 0);
    check_val("draw_pix_errors", bad_d, 0);
    check_val("idle_pix_errors", bad_o, 0);
    check_val("idle_after_row", extra, 0);
    $display("row %0d erase=%0b spam=%0b spur=%0b busy_cycles=%0d done_pulses=%0d slots=%0d gaps=%0d",
             id, with_erase, spam, spur_en, busy_cyc, done_cnt, n_draw, gaps);
  endtask

  initial begin
    int reached, busy1_cnt, draw1_cnt, done1_cnt, gap_i, done_i;
    bit prev1;
    reset_n = 1'b0;
    start   = 1'b0;
    erase   = 1'b0;
    spur    = 1'b0;
    start1  = 1'b0;
    erase1  = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_draw_en", draw_en, 0);
    check_val("rst_plot", plot, 0);
    check_val("rst_sym_x", sym_x, 0);
    check_val("rst_pix_x", pix_x, 0);
    check_val("rst1_pix_x", pix_x1, 0);
    $display("reset: busy=%0b done=%0b draw_en=%0b plot=%0b", busy, done, draw_en, plot);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_row(0, 1'b0, 1'b0, 1'b0);
    run_row(1, 1'b1, 1'b0, 1'b1);
    run_row(2, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset while slot 2 is drawing.
    @(negedge clk);
    start = 1'b1;
    erase = 1'b0;
    reached = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (draw_en && sym_x == 8'd48) begin
        reached = 1;
        break;
      end
    end
    check_val("reach_slot2", reached, 1);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_done", done, 0);
    check_val("midrst_draw_en", draw_en, 0);
    check_val("midrst_plot", plot, 0);
    check_val("midrst_sym_x", sym_x, 0);
    check_val("midrst_sym_y", sym_y, 0);
    check_val("midrst_pix_x", pix_x, 0);
    check_val("midrst_pix_y", pix_y, 0);
    check_val("midrst_pix_colour", pix_colour, 0);
    $display("mid-row reset: busy=%0b draw_en=%0b plot=%0b sym_x=%0d", busy, draw_en, plot, sym_x);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_row(3, 1'b0, 1'b0, 1'b0);

    // Single-slot instance: DRAW -> GAP -> FIN -> IDLE.
    busy1_cnt = 0; draw1_cnt = 0; done1_cnt = 0; gap_i = -10; done_i = -1;
    prev1 = 1'b0;
    @(negedge clk);
    start1 = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (busy1) busy1_cnt++;
      if (draw_en1) draw1_cnt++;
      if (done1) begin
        done1_cnt++;
        done_i = cyc;
      end
      if (prev1 && !draw_en1 && busy1 && !done1) gap_i = cyc;
      prev1 = draw_en1;
      if (done1_cnt > 0 && !busy1) break;
    end
    check_val("one_busy_cycles", busy1_cnt, TDRAW + 2);
    check_val("one_draw_cycles", draw1_cnt, TDRAW);
    check_val("one_done_pulses", done1_cnt, 1);
    check_val("one_done_after_gap", done_i, gap_i + 1);
    check_val("one_idle_busy", busy1, 0);
    $display("single slot: busy_cycles=%0d draw_cycles=%0d gap_at=%0d done_at=%0d",
             busy1_cnt, draw1_cnt, gap_i, done_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
